// File: rtl/spi_bus_bridge.sv
// SPI-slave (mode 0, MSB first) to bus bridge for the matrix accelerator array Controller.
// Optional error counter output err_cnt is enabled by defining SPI_BRIDGE_ERRCNT_EN.
module spi_bus_bridge #(
  parameter int WORD_SIZE   = 16,
  parameter int SYNC_STAGES = 2,
  parameter int VALID_HOLD  = 3,
  parameter int REQ_HOLD    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sclk,
  input  logic                 cs_n,
  input  logic                 mosi,
  output logic                 miso,
  output logic                 miso_oe,
  output logic                 rx_valid,
  output logic [WORD_SIZE-1:0] rx_data,
  output logic                 tx_ready,
  input  logic                 tx_valid,
  input  logic [WORD_SIZE-1:0] tx_data
`ifdef SPI_BRIDGE_ERRCNT_EN
  ,
  output logic [7:0]           err_cnt
`endif
);

  localparam int CNT_W  = $clog2(WORD_SIZE + 1);
  localparam int VCNT_W = $clog2(VALID_HOLD);
  localparam int RCNT_W = $clog2(REQ_HOLD);

  typedef enum logic {IDLE, SHIFT} frame_state_t;
  typedef enum logic [1:0] {TX_EMPTY, TX_REQ, TX_FULL} tx_state_t;

  frame_state_t state;
  tx_state_t    tx_state;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic sclk_s, cs_s, mosi_s, sclk_d, cs_d;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  logic [CNT_W-1:0]     bit_cnt;
  logic [WORD_SIZE-1:0] rx_shift, tx_shift, tx_buf, load_val;
  logic                 reload_pending;
  logic [VCNT_W-1:0]    valid_cnt;
  logic [RCNT_W-1:0]    req_cnt;
  logic                 buf_full, word_done, load;

  // cs_n chain resets high so that leaving reset never looks like a frame start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign miso_oe   = ~cs_s;

  assign buf_full  = (tx_state == TX_FULL);
  assign load_val  = buf_full ? tx_buf : '0;
  assign word_done = (state == SHIFT) && (bit_cnt == CNT_W'(WORD_SIZE));
  assign load      = ((state == IDLE) && cs_fall) ||
                     ((state == SHIFT) && !cs_rise && sclk_fall && reload_pending);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      rx_shift       <= '0;
      tx_shift       <= '0;
      miso           <= 1'b0;
      reload_pending <= 1'b0;
      rx_data        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state          <= SHIFT;
            bit_cnt        <= '0;
            reload_pending <= 1'b0;
            tx_shift       <= load_val;
            miso           <= load_val[WORD_SIZE-1];
          end
        end
        SHIFT: begin
          if (word_done) begin
            rx_data        <= rx_shift;
            bit_cnt        <= '0;
            reload_pending <= 1'b1;
          end
          if (cs_rise) begin
            state          <= IDLE;
            bit_cnt        <= '0;
            miso           <= 1'b0;
            reload_pending <= 1'b0;
          end else if (sclk_rise) begin
            rx_shift <= {rx_shift[WORD_SIZE-2:0], mosi_s};
            bit_cnt  <= bit_cnt + CNT_W'(1);
          end else if (sclk_fall) begin
            // The first fall after a completed word starts the next outgoing word
            if (reload_pending) begin
              tx_shift       <= load_val;
              miso           <= load_val[WORD_SIZE-1];
              reload_pending <= 1'b0;
            end else begin
              tx_shift <= tx_shift << 1;
              miso     <= tx_shift[WORD_SIZE-2];
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_valid  <= 1'b0;
      valid_cnt <= '0;
    end else if (word_done) begin
      rx_valid  <= 1'b1;
      valid_cnt <= VCNT_W'(VALID_HOLD - 1);
    end else if (valid_cnt != '0) begin
      valid_cnt <= valid_cnt - VCNT_W'(1);
    end else begin
      rx_valid <= 1'b0;
    end
  end

  // A load in the same cycle as a latch sees the old (empty) buffer, so the word survives
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= TX_EMPTY;
      tx_ready <= 1'b0;
      req_cnt  <= '0;
      tx_buf   <= '0;
    end else begin
      case (tx_state)
        TX_EMPTY: begin
          tx_state <= TX_REQ;
          tx_ready <= 1'b1;
          req_cnt  <= '0;
        end
        TX_REQ: begin
          if (req_cnt == RCNT_W'(REQ_HOLD - 1)) begin
            tx_ready <= 1'b0;
            if (tx_valid) begin
              tx_buf   <= tx_data;
              tx_state <= TX_FULL;
            end else begin
              tx_state <= TX_EMPTY;
            end
          end else begin
            req_cnt <= req_cnt + RCNT_W'(1);
          end
        end
        TX_FULL: begin
          if (load) tx_state <= TX_EMPTY;
        end
        default: begin
          tx_state <= TX_EMPTY;
          tx_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPI_BRIDGE_ERRCNT_EN
  logic underrun, partial_abort;

  assign underrun      = load && !buf_full;
  assign partial_abort = (state == SHIFT) && cs_rise && (bit_cnt != '0) && !word_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt <= '0;
    end else if ((underrun || partial_abort) && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule
